// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling FIFO carrying {pc, instr, prediction} bundles under valid/ready.
// Active-low flush_ discards every held bundle plus the push/pop of the flush cycle.
module if_id_queue #(
  parameter int unsigned     XLEN  = 32,
  parameter int unsigned     DEPTH = 2,
  parameter logic [XLEN-1:0] NOP   = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    if_valid,
  input  logic [XLEN-1:0]         if_pc,
  input  logic [XLEN-1:0]         if_instr,
  input  logic                    if_pred_taken,
  input  logic [XLEN-1:0]         if_pred_target,
  output logic                    if_ready,
  input  logic                    flush_,
  input  logic                    id_ready,
  output logic                    id_valid,
  output logic [XLEN-1:0]         id_pc,
  output logic [XLEN-1:0]         id_pc_plus4,
  output logic [XLEN-1:0]         id_instr,
  output logic                    id_pred_taken,
  output logic [XLEN-1:0]         id_pred_target,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [XLEN-1:0] pc_q     [DEPTH];
  logic [XLEN-1:0] instr_q  [DEPTH];
  logic [XLEN-1:0] target_q [DEPTH];
  logic            taken_q  [DEPTH];

  logic push;
  logic pop;

  // if_ready depends on count only; a same-cycle pop never frees a slot early.
  assign if_ready  = (count_q != Full);
  assign id_valid  = (count_q != '0);
  assign push      = if_valid & if_ready & flush_;
  assign pop       = id_valid & id_ready & flush_;
  assign occupancy = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (!flush_) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]     <= '0;
        instr_q[i]  <= '0;
        target_q[i] <= '0;
        taken_q[i]  <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        pc_q[wr_ptr_q]     <= if_pc;
        instr_q[wr_ptr_q]  <= if_instr;
        target_q[wr_ptr_q] <= if_pred_target;
        taken_q[wr_ptr_q]  <= if_pred_taken;
      end
    end
  end

  // Head is gated by id_valid so stale storage never reaches decode.
  always_comb begin
    id_pc          = '0;
    id_pc_plus4    = '0;
    id_instr       = NOP;
    id_pred_taken  = 1'b0;
    id_pred_target = '0;
    if (id_valid) begin
      id_pc          = pc_q[rd_ptr_q];
      id_pc_plus4    = pc_q[rd_ptr_q] + XLEN'(4);
      id_instr       = instr_q[rd_ptr_q];
      id_pred_taken  = taken_q[rd_ptr_q];
      id_pred_target = target_q[rd_ptr_q];
    end
  end

endmodule
